// File: rtl/print_sched_if.sv
// Character-in and byte-transmit handshake bundle for the print scheduler.
// master: the environment (typewriter input path and serial transmitter).
// slave:  the scheduler itself.
interface print_sched_if;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic       tx_done;

   modport master (
      output char_in, char_valid, tx_done,
      input  char_ready, tx_byte, tx_start
   );

   modport slave (
      input  char_in, char_valid, tx_done,
      output char_ready, tx_byte, tx_start
   );
endinterface

// File: rtl/print_sched.sv
// Print scheduler: buffers typed characters in a circular FIFO and feeds them
// one at a time to a serial byte transmitter. Sends a wake byte after power-up,
// inserts an idle gap after every byte, and breaks lines longer than LINE_LEN.
module print_sched #(
   parameter int DEPTH      = 16,
   parameter int LINE_LEN   = 32,
   parameter int WAKE_DELAY = 50000000,
   parameter int GAP_CYCLES = 2604
) (
   input  logic         clk,
   input  logic         rst_l,
   print_sched_if.slave bus,
   output logic         busy,
   output logic         overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LINE_LEN + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [25:0]   WAKE_LAST = 26'(WAKE_DELAY - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] COL_MAX   = CW'(LINE_LEN);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
   localparam logic [7:0]    WAKE_BYTE = 8'hFF;
   localparam logic [7:0]    LF        = 8'h0A;

   typedef enum logic [2:0] {S_WAIT, S_WAKE, S_IDLE, S_SEND, S_NL, S_GAP} state_t;

   state_t        state, state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [25:0]   wait_cnt;
   logic [GW-1:0] gap_cnt;
   logic [CW-1:0] col;
   logic [7:0]    tx_byte_q;
   logic          tx_start_q;
   logic [7:0]    head;
   logic          full, pop, push, drop, enter_tx;

   assign head = mem[rd_ptr];
   assign full = (count == CNT_FULL);
   assign pop  = (state == S_SEND) && bus.tx_done;
   // char_ready reflects the pre-pop count, but a slot freed by a pop on the
   // same edge still takes the offered byte, so it is neither lost nor flagged.
   assign push = bus.char_valid && (!full || pop);
   assign drop = bus.char_valid && full && !pop;

   assign bus.char_ready = !full;
   assign bus.tx_byte    = tx_byte_q;
   assign bus.tx_start   = tx_start_q;
   assign busy           = (state != S_IDLE);

   // next-state selection and detection of entry into a transmitting state
   always_comb begin
      state_nx = state;
      enter_tx = 1'b0;
      case (state)
         S_WAIT: if (wait_cnt == WAKE_LAST) state_nx = S_WAKE;
         S_WAKE: if (bus.tx_done) state_nx = S_GAP;
         S_IDLE: begin
            if (count != '0) begin
               if (col == COL_MAX && head != LF) state_nx = S_NL;
               else                              state_nx = S_SEND;
            end
         end
         S_SEND: if (bus.tx_done) state_nx = S_GAP;
         S_NL:   if (bus.tx_done) state_nx = S_GAP;
         S_GAP:  if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
         default: state_nx = S_WAIT;
      endcase
      // transmitting states are only ever entered from another state
      if (state_nx != state &&
          (state_nx == S_WAKE || state_nx == S_SEND || state_nx == S_NL))
         enter_tx = 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= S_WAIT;
      else        state <= state_nx;
   end

   // power-up wait counter and post-byte gap counter
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wait_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         if (state == S_WAIT) wait_cnt <= wait_cnt + 26'd1;
         if (state == S_GAP)  gap_cnt  <= gap_cnt + GW'(1);
         else                 gap_cnt  <= '0;
      end
   end

   // FIFO storage; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.char_in;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   // column tracking: updated when a byte completes, not when it starts
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         col <= '0;
      end else if (pop) begin
         if (head == LF)         col <= '0;
         else if (col != COL_MAX) col <= col + CW'(1);
      end else if (state == S_NL && bus.tx_done) begin
         col <= '0;
      end
   end

   // transmit byte latched on entry and held; start pulses for one cycle
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         tx_byte_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= enter_tx;
         if (enter_tx) begin
            case (state_nx)
               S_WAKE:  tx_byte_q <= WAKE_BYTE;
               S_NL:    tx_byte_q <= LF;
               default: tx_byte_q <= head;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_print_sched.sv
// Bench for print_sched: transaction-level reference model (byte queue, column,
// event-cycle arithmetic) checked every cycle, plus directed literal scenarios.
module tb_print_sched;
   localparam int DEPTH = 4;
   localparam int LINE  = 4;
   localparam int WAKE  = 10;
   localparam int GAP   = 4;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   logic busy, overflow;
   print_sched_if pif ();

   print_sched #(.DEPTH(DEPTH), .LINE_LEN(LINE), .WAKE_DELAY(WAKE), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_l(rst_l), .bus(pif), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_WAIT, M_TX, M_GAP} mmode_t;
   mmode_t     mode = M_WAIT;
   logic [7:0] mq[$];
   logic [7:0] log_q[$];
   int         cyc = 0, idle_at = 0, start_cyc = -1, first_start = -1, mcol = 0, kind = 0;
   logic [7:0] cur = 8'h00;
   bit         ovf = 0;

   // kind: 0 wake byte, 1 FIFO byte, 2 inserted line feed
   always @(posedge clk) begin
      if (!rst_l) begin
         mq.delete(); log_q.delete();
         cyc = 0; mode = M_WAIT; mcol = 0; ovf = 0; first_start = -1; start_cyc = -1;
      end else begin
         bit popping, accept;
         logic [7:0] b;
         popping = 0; accept = 0;
         cyc++;
         case (mode)
            M_WAIT: if (cyc == WAKE) begin
               mode = M_TX; cur = 8'hFF; kind = 0; start_cyc = cyc;
               log_q.push_back(cur);
               if (first_start < 0) first_start = cyc;
            end
            M_TX: if (pif.tx_done) begin
               if (kind == 1) popping = 1;
               if (kind == 2) mcol = 0;
               mode = M_GAP; idle_at = cyc + GAP;
            end
            M_GAP: if (cyc - 1 >= idle_at && mq.size() > 0) begin
               mode = M_TX; start_cyc = cyc;
               if (mcol == LINE && mq[0] != 8'h0A) begin cur = 8'h0A; kind = 2; end
               else begin cur = mq[0]; kind = 1; end
               log_q.push_back(cur);
            end
            default: ;
         endcase
         if (pif.char_valid) begin
            if (mq.size() < DEPTH || popping) accept = 1;
            else ovf = 1;
         end
         if (popping) begin
            b = mq.pop_front();
            if (b == 8'h0A) mcol = 0;
            else if (mcol < LINE) mcol++;
         end
         if (accept) mq.push_back(pif.char_in);
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst_l) begin
         check("rst_tx_start", pif.tx_start, 0);
         check("rst_busy", busy, 1);
         check("rst_char_ready", pif.char_ready, 1);
         check("rst_overflow", overflow, 0);
         check("rst_tx_byte", pif.tx_byte, 8'h00);
      end else begin
         check("tx_start", pif.tx_start, (mode == M_TX && cyc == start_cyc));
         if (mode == M_TX) check("tx_byte", pif.tx_byte, cur);
         check("busy", busy, !(mode == M_GAP && cyc >= idle_at));
         check("char_ready", pif.char_ready, mq.size() < DEPTH);
         check("overflow", overflow, ovf);
      end
   end

   // ---------------- transmitter model ----------------
   bit man_mode = 0, man_done = 0, spur_en = 0;
   initial begin
      bit pending;
      int dly;
      pending = 0; dly = 0;
      pif.tx_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         pif.tx_done = 1'b0;
         if (!rst_l) begin
            pending = 0;
         end else if (man_mode) begin
            pif.tx_done = man_done;
            man_done = 0;
            pending = 0;
         end else begin
            if (pif.tx_start) begin pending = 1; dly = $urandom_range(0, 4); end
            if (pending) begin
               if (dly == 0) begin pif.tx_done = 1'b1; pending = 0; end
               else dly--;
            end else if (spur_en && $urandom_range(0, 15) == 0) begin
               pif.tx_done = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus helpers (enter/leave at posedge+1) ----------------
   task automatic do_reset();
      rst_l = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;
   endtask

   task automatic push_wait(input logic [7:0] c);
      int n = 0;
      while (!pif.char_ready && n < 500) begin @(posedge clk); #1; n++; end
      n_tests++;
      if (n >= 500) begin n_fail++; $display("FAIL push_timeout: char %0h never accepted", c); end
      pif.char_valid = 1'b1; pif.char_in = c;
      @(posedge clk); #1;
      pif.char_valid = 1'b0;
   endtask

   task automatic push_now(input logic [7:0] c);
      pif.char_valid = 1'b1; pif.char_in = c;
      @(posedge clk); #1;
      pif.char_valid = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!pif.tx_start && n < 500);
      n_tests++;
      if (n >= 500) begin n_fail++; $display("FAIL start_timeout: no tx_start within 500 cycles"); end
   endtask

   task automatic pulse_done();
      @(negedge clk); man_done = 1;
      @(posedge clk); #1;
   endtask

   task automatic wait_quiet(input int need);
      int n = 0;
      while (!(log_q.size() >= need && busy == 1'b0 && mq.size() == 0) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      n_tests++;
      if (n >= 3000) begin n_fail++; $display("FAIL quiet_timeout: got %0d bytes wanted %0d", log_q.size(), need); end
   endtask

   task automatic cmp_log(input string nm, input logic [7:0] e[$]);
      check({nm, "_len"}, log_q.size(), e.size());
      for (int i = 0; i < e.size() && i < log_q.size(); i++)
         check(nm, log_q[i], e[i]);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      logic [7:0] e[$];
      pif.char_valid = 1'b0; pif.char_in = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;

      // power-up wake timing and order with characters pushed while waiting
      push_wait(8'h41); push_wait(8'h42); push_wait(8'h43);
      wait_quiet(4);
      check("first_start", first_start, 10);
      e = '{8'hFF, 8'h41, 8'h42, 8'h43};
      cmp_log("order_abc", e);
      check("idle_after_abc", busy, 0);

      // automatic line feed after LINE_LEN characters
      do_reset();
      push_wait(8'h41); push_wait(8'h42); push_wait(8'h43); push_wait(8'h44); push_wait(8'h45);
      wait_quiet(7);
      e = '{8'hFF, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h45};
      cmp_log("auto_lf", e);

      // explicit line feed suppresses the automatic one
      do_reset();
      push_wait(8'h41); push_wait(8'h42); push_wait(8'h43); push_wait(8'h44);
      push_wait(8'h0A); push_wait(8'h45);
      wait_quiet(7);
      cmp_log("user_lf", e);

      // full FIFO with stalled transmitter: excess dropped, overflow sticky
      do_reset();
      man_mode = 1;
      push_now(8'h41); push_now(8'h42); push_now(8'h43);
      check("ready_at3", pif.char_ready, 1);
      push_now(8'h44);
      check("ready_full", pif.char_ready, 0);
      check("ovf_at4", overflow, 0);
      push_now(8'h45);
      check("ovf_at5", overflow, 1);
      push_now(8'h46);
      repeat (20) @(posedge clk);
      #1;
      pulse_done();
      man_mode = 0;
      wait_quiet(5);
      e = '{8'hFF, 8'h41, 8'h42, 8'h43, 8'h44};
      cmp_log("full_drop", e);
      check("ovf_sticky", overflow, 1);

      // push and pop on the same edge while full
      do_reset();
      man_mode = 1;
      push_now(8'h41); push_now(8'h42); push_now(8'h43); push_now(8'h44);
      wait_start();
      pulse_done();
      wait_start();
      check("send_a_byte", pif.tx_byte, 8'h41);
      @(negedge clk); man_done = 1;
      @(posedge clk); #1;
      pif.char_valid = 1'b1; pif.char_in = 8'h58;
      @(posedge clk); #1;
      pif.char_valid = 1'b0;
      check("pushpop_ready", pif.char_ready, 0);
      check("pushpop_ovf", overflow, 0);
      man_mode = 0;
      wait_quiet(7);
      e = '{8'hFF, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h58};
      cmp_log("pushpop", e);

      // reset during a data transfer aborts it and restarts the wake sequence
      do_reset();
      push_wait(8'h41); push_wait(8'h42);
      wait_start();
      wait_start();
      check("mid_send_byte", pif.tx_byte, 8'h41);
      #1 rst_l = 1'b0;
      #1;
      check("abort_tx_start", pif.tx_start, 0);
      check("abort_busy", busy, 1);
      @(posedge clk); @(posedge clk);
      #1 rst_l = 1'b1;
      repeat (40) begin @(posedge clk); #1; end
      e = '{8'hFF};
      cmp_log("after_abort", e);
      check("abort_first_start", first_start, 10);
      check("abort_idle", busy, 0);

      // randomized traffic with spurious tx_done pulses
      do_reset();
      spur_en = 1;
      for (int i = 0; i < 3000; i++) begin
         pif.char_valid = ($urandom_range(0, 2) == 0);
         pif.char_in = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
         @(posedge clk); #1;
      end
      pif.char_valid = 1'b0;
      wait_quiet(1);
      check("rand_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/print_sched.md
PRINT_SCHED -- requirements
Module: print_sched

Interface
REQ-001 Parameter DEPTH, default 16: character FIFO depth; power of two, 2..256.
REQ-002 Parameter LINE_LEN, default 32: printable characters per line before an automatic line feed is inserted.
REQ-003 Parameter WAKE_DELAY, default 50000000: clk cycles from reset release to the wake byte (1 s at 50 MHz).
REQ-004 Parameter GAP_CYCLES, default 2604: idle clk cycles inserted after every transmitted byte.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst_l  in  1  reset; asynchronous, active-low.
REQ-007 char_in  in  8  character from the typewriter input path.
REQ-008 char_valid  in  1  char_in is valid this cycle.
REQ-009 char_ready  out  1  FIFO not full; a character is accepted on a clk edge where char_valid && char_ready.
REQ-010 tx_byte  out  8  byte presented to the serial byte transmitter.
REQ-011 tx_start  out  1  one-cycle pulse that starts the transmitter on tx_byte.
REQ-012 tx_done  in  1  one-cycle pulse from the transmitter when the stop bit completes.
REQ-013 busy  out  1  high in every state except S_IDLE.
REQ-014 overflow  out  1  sticky flag: a character was offered while the FIFO was full.

Function
REQ-015 The FSM SHALL have the states S_WAIT, S_WAKE, S_IDLE, S_SEND, S_NL and S_GAP.
REQ-016 S_WAIT: a 26-bit counter increments each cycle; the FSM moves to S_WAKE on the cycle the count equals WAKE_DELAY-1.
REQ-017 S_WAKE: tx_byte=0xFF and tx_start pulses on the first cycle in the state; the FSM moves to S_GAP on tx_done.
REQ-018 S_IDLE: if the FIFO is non-empty, the FSM moves to S_NL when col==LINE_LEN and the head byte is not 0x0A; otherwise it moves to S_SEND.
REQ-019 S_SEND: tx_byte=FIFO head, held stable; tx_start pulses on the first cycle in the state; on tx_done the FIFO pops and the FSM moves to S_GAP.
REQ-020 S_NL: tx_byte=0x0A and tx_start pulses on entry; on tx_done col clears to 0, nothing pops, and the FSM moves to S_GAP.
REQ-021 S_GAP: a counter runs for GAP_CYCLES cycles, then the FSM moves to S_IDLE.
REQ-022 tx_start SHALL be high for exactly one cycle per transmitted byte; it is never high outside S_WAKE, S_SEND or S_NL.
REQ-023 tx_done received in any state other than S_WAKE, S_SEND or S_NL SHALL be ignored.
REQ-024 Column counter col, width clog2(LINE_LEN+1): a sent 0x0A sets col to 0; any other sent byte increments col, saturating at LINE_LEN.
REQ-025 The FIFO SHALL be a circular buffer with wrapping read/write pointers and an occupancy count of clog2(DEPTH)+1 bits.
REQ-026 Push and pop on the same edge SHALL leave the count unchanged and store the pushed byte.
REQ-027 When full, char_ready=0 (based on the pre-pop count); a char_valid offered while full is dropped and sets overflow.
REQ-028 Latency: a character accepted into an empty FIFO while in S_IDLE (col<LINE_LEN) SHALL produce tx_start in the second cycle after the accepting edge.
REQ-029 Characters SHALL be transmitted in acceptance order with none lost, duplicated or reordered.

Reset
REQ-030 While rst_l=0: state=S_WAIT, all counters=0, FIFO empty, col=0, tx_byte=0x00, tx_start=0, busy=1, overflow=0, char_ready=1.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer immediately, discard FIFO contents, and restart the wake sequence.
REQ-032 Characters SHALL be accepted in S_WAIT and S_WAKE and transmitted only after the wake byte completes.

Verification
REQ-033 Power-up, WAKE_DELAY=10, GAP_CYCLES=4: first tx_start at cycle 10 after reset release with tx_byte=0xFF; no further tx_start until 4 cycles after tx_done.
REQ-034 Push 'A','B','C' during S_WAIT: the transmit order is 0xFF, 0x41, 0x42, 0x43; busy=0 once the final gap ends.
REQ-035 LINE_LEN=4, push "ABCDE": the transmit order is A B C D 0x0A E; push "ABCD\nE": no extra 0x0A is inserted.
REQ-036 DEPTH=4, transmitter stalled, push 6 characters: char_ready=0 after the 4th push; overflow=1 after the 5th; only the first 4 characters are sent.
REQ-037 Full FIFO with simultaneous push and tx_done pop on the same edge: the count stays 4, the new byte is kept, and overflow stays 0.
REQ-038 Assert rst_l=0 during S_SEND: tx_start=0 and busy=1 at once; after release, only 0xFF is transmitted, after WAKE_DELAY cycles.
